// File: rtl/tick_period_meter_if.sv
// Tick stream and period-measurement results exchanged between a tick source
// and the tick_period_meter.
interface tick_period_meter_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   tick;
    logic [COUNT_WIDTH-1:0] period;
    logic                   period_valid;
    logic                   locked;
    logic                   timeout;

    modport master (
        output tick,
        input  period,
        input  period_valid,
        input  locked,
        input  timeout
    );

    modport slave (
        input  tick,
        output period,
        output period_valid,
        output locked,
        output timeout
    );
endinterface

// File: rtl/tick_period_meter.sv
// Recovers the spacing of a single-cycle tick stream in clock cycles and flags
// lock once LOCK_COUNT consecutive measurements agree.
module tick_period_meter #(
    parameter int COUNT_WIDTH = 8,
    parameter int LOCK_COUNT  = 4
) (
    input  logic              clock,
    input  logic              reset,
    tick_period_meter_if.slave bus
);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
    localparam logic [MATCH_W-1:0]     LOCK_VAL = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0]     MATCH_ONE = MATCH_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t                 state_r;
    logic [COUNT_WIDTH-1:0] cnt_r;
    logic [MATCH_W-1:0]     match_r;
    logic [COUNT_WIDTH-1:0] period_r;
    logic                   period_valid_r;
    logic                   locked_r;
    logic                   timeout_r;
    logic                   same_s;
    logic [MATCH_W-1:0]     match_next_s;

    // Match-run length after a measurement; compares against the period held before this tick.
    always_comb begin
        same_s       = (cnt_r == period_r);
        match_next_s = MATCH_ONE;
        if (same_s && (match_r != '0)) begin
            if (match_r == LOCK_VAL) begin
                match_next_s = LOCK_VAL;
            end else begin
                match_next_s = match_r + MATCH_ONE;
            end
        end else begin
            match_next_s = MATCH_ONE;
        end
    end

    // Measurement FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= IDLE;
            cnt_r          <= '0;
            match_r        <= '0;
            period_r       <= '0;
            period_valid_r <= 1'b0;
            locked_r       <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            period_valid_r <= 1'b0;
            timeout_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    locked_r <= 1'b0;
                    if (bus.tick) begin
                        cnt_r   <= CNT_ONE;
                        match_r <= '0;
                        state_r <= ACQUIRE;
                    end else begin
                        cnt_r <= '0;
                    end
                end
                ACQUIRE, LOCKED: begin
                    if (bus.tick) begin
                        period_r       <= cnt_r;
                        period_valid_r <= 1'b1;
                        cnt_r          <= CNT_ONE;
                        match_r        <= match_next_s;
                        // A mismatch in LOCKED yields match_next_s == 1, which is never LOCK_VAL unless LOCK_COUNT is 1.
                        if (match_next_s == LOCK_VAL) begin
                            state_r  <= LOCKED;
                            locked_r <= 1'b1;
                        end else begin
                            state_r  <= ACQUIRE;
                            locked_r <= 1'b0;
                        end
                    end else if (cnt_r == CNT_MAX) begin
                        timeout_r <= 1'b1;
                        state_r   <= IDLE;
                        locked_r  <= 1'b0;
                        match_r   <= '0;
                        cnt_r     <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    cnt_r    <= '0;
                    match_r  <= '0;
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.period       = period_r;
    assign bus.period_valid = period_valid_r;
    assign bus.locked       = locked_r;
    assign bus.timeout      = timeout_r;
endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: a tick-history model predicts every
// output each cycle, with literal spot checks at the key events.
module tb_tick_period_meter;
    localparam int CW  = 8;
    localparam int LC  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;

    tick_period_meter_if #(.COUNT_WIDTH(CW)) bus ();

    tick_period_meter #(.COUNT_WIDTH(CW), .LOCK_COUNT(LC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // model: reference seen, cycles since last tick, measurements since reference
    bit have_ref = 1'b0;
    int elapsed  = 0;
    int meas[$];
    int exp_period = 0;
    bit exp_pv = 1'b0;
    bit exp_to = 1'b0;
    bit exp_locked = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_locked();
        int n;
        n = meas.size();
        if (!have_ref || n < LC) return 1'b0;
        for (int k = 1; k < LC; k++) begin
            if (meas[n-1-k] != meas[n-1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step(input bit t, input bit r);
        exp_pv = 1'b0;
        exp_to = 1'b0;
        if (r) begin
            have_ref = 1'b0;
            meas.delete();
            exp_period = 0;
        end else if (!have_ref) begin
            if (t) begin
                have_ref = 1'b1;
                elapsed  = 0;
                meas.delete();
            end
        end else begin
            elapsed++;
            if (t) begin
                exp_period = elapsed;
                exp_pv     = 1'b1;
                meas.push_back(elapsed);
                elapsed    = 0;
            end else if (elapsed == MAX) begin
                exp_to   = 1'b1;
                have_ref = 1'b0;
                meas.delete();
            end
        end
        exp_locked = model_locked();
    endtask

    // one clock: drive, let the edge sample, then compare every output against the model
    task automatic cycle(input bit t, input bit r);
        bus.tick = t;
        reset    = r;
        @(posedge clock);
        #1;
        model_step(t, r);
        chk("period", int'(bus.period), exp_period);
        chk("period_valid", int'(bus.period_valid), int'(exp_pv));
        chk("locked", int'(bus.locked), int'(exp_locked));
        chk("timeout", int'(bus.timeout), int'(exp_to));
        chk("pv_to_exclusive", int'(bus.period_valid & bus.timeout), 0);
    endtask

    // n-1 idle cycles followed by a tick: spacing n from the previous tick
    task automatic gap(input int n);
        for (int i = 1; i < n; i++) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
    endtask

    initial begin
        bus.tick = 1'b0;
        repeat (3) cycle(1'b0, 1'b1);
        chk("rst_period", int'(bus.period), 0);
        chk("rst_locked", int'(bus.locked), 0);

        // steady spacing 5 from a prescaler
        for (int i = 0; i <= 25; i++) begin
            cycle((i % 5) == 0, 1'b0);
            if (i == 15) chk("lock_before_5th", int'(bus.locked), 0);
            if (i == 20) begin
                chk("lock_at_5th", int'(bus.locked), 1);
                chk("pv_at_5th", int'(bus.period_valid), 1);
                chk("period5", int'(bus.period), 5);
            end
        end

        // single gap of 7 breaks lock; four more 5s relock
        gap(7);
        chk("gap7_period", int'(bus.period), 7);
        chk("gap7_unlock", int'(bus.locked), 0);
        for (int k = 1; k <= 4; k++) begin
            gap(5);
            chk("relock", int'(bus.locked), (k == 4) ? 1 : 0);
        end

        // move to period 10, then stop ticking
        for (int k = 0; k < 5; k++) gap(10);
        chk("lock10", int'(bus.locked), 1);
        for (int i = 1; i < MAX; i++) cycle(1'b0, 1'b0);
        chk("no_early_timeout", int'(bus.timeout), 0);
        cycle(1'b0, 1'b0);
        chk("timeout_255", int'(bus.timeout), 1);
        chk("timeout_unlock", int'(bus.locked), 0);
        chk("timeout_keeps_period", int'(bus.period), 10);
        cycle(1'b1, 1'b0);
        chk("ref_after_timeout_no_pv", int'(bus.period_valid), 0);

        // spacing 255 measures, spacing 256 times out
        gap(255);
        chk("period_max", int'(bus.period), MAX);
        chk("period_max_pv", int'(bus.period_valid), 1);
        gap(256);
        chk("gap256_no_pv", int'(bus.period_valid), 0);

        // tick held high
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0);
            if (i == 1) chk("cont_period1", int'(bus.period), 1);
            if (i == 3) chk("cont_unlocked", int'(bus.locked), 0);
            if (i == 4) chk("cont_locked", int'(bus.locked), 1);
        end

        // reset mid-acquire, then a full relock is needed
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        gap(3);
        gap(3);
        cycle(1'b0, 1'b1);
        chk("midrst_period", int'(bus.period), 0);
        chk("midrst_pv", int'(bus.period_valid), 0);
        cycle(1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            gap(3);
            chk("post_rst_lock", int'(bus.locked), (k == 4) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Measures the spacing, in clock cycles, between single-cycle enable ticks and reports it with a lock indication. It is the receive-side counterpart of the prescaler. The prescaler turns a limit into a periodic clock_enable. This block takes such a tick stream and recovers the limit. It sits downstream of any tick source in the RGB/PWM datapath and lets logic check or adapt to the tick rate.

## Interface
Parameters:
- COUNT_WIDTH, 8, width of cycle counter and period output; max measurable period 2^COUNT_WIDTH-1
- LOCK_COUNT, 4, consecutive identical measurements required to assert locked; legal range ≥1

Ports:
- clock  in  1  system clock; reset, synchronous, active-high; clock clock
- reset  in  1  synchronous, active-high
- tick  in  1  enable strobe, synchronous to clock; may be high on consecutive cycles
- period  out  COUNT_WIDTH  last measured tick spacing in cycles
- period_valid  out  1  one-cycle pulse: period updated this cycle
- locked  out  1  high while the last LOCK_COUNT measurements were equal
- timeout  out  1  one-cycle pulse: no tick within 2^COUNT_WIDTH-1 cycles

## Operation
- Internal state:
  - cnt: COUNT_WIDTH bits, cycles since last tick.
  - match: counter sized to hold LOCK_COUNT.
  - FSM: IDLE, ACQUIRE, LOCKED.
- Period definition: ticks at cycles t and t+N give period = N. A tick high every cycle gives period = 1.
- All outputs are registered. locked = (state == LOCKED).
- IDLE (no reference tick yet):
  - cnt is held at 0.
  - tick → cnt<=1, match<=0, go to ACQUIRE. No period_valid.
- ACQUIRE and LOCKED, on a cycle with tick=1:
  - period<=cnt, period_valid<=1, cnt<=1.
  - Measurement equals the currently held period and match≠0 → match<=match+1, saturating at LOCK_COUNT.
  - Otherwise → match<=1.
  - ACQUIRE: new match value = LOCK_COUNT → LOCKED.
  - LOCKED: measurement ≠ held period → ACQUIRE with match<=1. Otherwise stay in LOCKED.
- ACQUIRE and LOCKED, on a cycle with tick=0:
  - cnt<MAX → cnt<=cnt+1.
  - cnt==MAX (2^COUNT_WIDTH-1) → timeout<=1, state<=IDLE, match<=0, cnt<=0. period keeps its last value.
- Boundary cases:
  - tick on the same cycle as cnt==MAX: a valid measurement, period=MAX, no timeout.
  - LOCK_COUNT=1: the first measurement locks.
  - The comparison for a measurement always uses the period value held before that tick's update.
- Reset (any state, mid-measurement included):
  - state=IDLE, cnt=0, match=0, period=0.
  - period_valid=0, locked=0, timeout=0.
  - Any partial measurement is discarded.

## Timing
- tick sampled at edge k → period, period_valid, locked and state change are visible after edge k (one-cycle latency).
- period_valid and timeout are high for exactly one cycle per event. They are never high in the same cycle.
- Lock latency with a steady source of spacing N:
  - first tick seen at edge t0.
  - locked rises after edge t0 + LOCK_COUNT·N, i.e. the (LOCK_COUNT+1)-th tick.
  - It rises in the same cycle as that measurement's period_valid.
- Unlock: locked falls after the edge that samples the first mismatching tick, or after the timeout edge.
- Timeout: last tick at edge t → timeout pulse after edge t+MAX, if ticks at t+1..t+MAX are all 0.
- Widths:
  - cnt saturates and never wraps.
  - Comparisons are unsigned and COUNT_WIDTH wide.
  - match width is ceil(log2(LOCK_COUNT+1)) bits.

## Test plan
- Prescaler limit=5 drives tick, defaults used, reset released:
  - period_valid every 5 cycles, period=5.
  - locked rises on the 5th tick's period_valid cycle.
  - timeout never fires.
- tick held high continuously → period=1 from the 2nd cycle, period_valid every cycle, locked after 5 ticks.
- Locked at period 5, then a single gap of 7:
  - period=7, locked falls on that measurement.
  - locked rises again after 4 further equal measurements (the first of them is period 5, then match restarts).
- Locked at period 10, ticks stopped:
  - timeout pulses exactly 255 cycles after the last tick edge; locked falls with it.
  - period stays 10.
  - The next tick produces no period_valid.
- Ticks spaced 255 apart → period=255, no timeout. Spacing 256 → timeout, no period_valid for that interval.
- Reset asserted mid-ACQUIRE (2 matches accumulated) → all outputs 0 on the next cycle. After release, lock needs a full 5 ticks again.
